toggle_driver: RTL and testbench

TOGGLE_DRIVER -- requirements
Module: toggle_driver

---
 rtl/toggle_driver.sv | 116 +++++++++++
 tb/tb_toggle_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_driver.sv
// Runs a worker `runs` times via single-cycle go pulses, counting completions, ones and watchdog aborts.
// go follows an accepted start by one cycle; finished follows the final completion edge; start is ignored while busy.
module toggle_driver #(
  parameter int RUNW    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [RUNW-1:0] runs,
  output logic            go,
  input  logic            done_in,
  input  logic            data_in,
  output logic            busy,
  output logic            finished,
  output logic [RUNW-1:0] ones,
  output logic [RUNW-1:0] completed,
  output logic            timeout
);

  localparam int             WDW     = 16;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RUNW-1:0] remaining;
  logic [WDW-1:0]  watchdog;
  logic            go_nxt;
  logic            busy_nxt;
  logic            finished_nxt;
  logic            wd_expire;
  logic            last_run;

  assign wd_expire = (watchdog == WD_LAST);
  assign last_run  = (remaining == RUNW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      go       <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_nxt;
      go       <= go_nxt;
      busy     <= busy_nxt;
      finished <= finished_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (runs != '0) ? S_LAUNCH : S_FINISH;
      S_LAUNCH: state_nxt = S_WAIT;
      // A completion on the last watchdog cycle beats the abort.
      S_WAIT: begin
        if (done_in)        state_nxt = last_run ? S_FINISH : S_GAP;
        else if (wd_expire) state_nxt = S_FINISH;
      end
      S_GAP:    if (!done_in) state_nxt = S_LAUNCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they register alongside it.
  always_comb begin
    go_nxt       = (state_nxt == S_LAUNCH);
    busy_nxt     = (state_nxt != S_IDLE);
    finished_nxt = (state_nxt == S_FINISH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
      watchdog  <= '0;
      ones      <= '0;
      completed <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= runs;
            watchdog  <= '0;
            ones      <= '0;
            completed <= '0;
            timeout   <= 1'b0;
          end
        end
        S_LAUNCH: watchdog <= '0;
        S_WAIT: begin
          if (done_in) begin
            completed <= completed + RUNW'(1);
            remaining <= remaining - RUNW'(1);
            if (data_in) ones <= ones + RUNW'(1);
          end else begin
            watchdog <= watchdog + WDW'(1);
            if (wd_expire) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_driver.sv
// Bench for toggle_driver: behavioural worker, table vectors, reset/start corner cases and random batches.
module tb_toggle_driver;

  localparam int RUNW = 8;
  localparam int TO   = 8;

  logic            clock   = 1'b0;
  logic            reset   = 1'b1;
  logic            start   = 1'b0;
  logic [RUNW-1:0] runs    = '0;
  logic            done_in = 1'b0;
  logic            data_in = 1'b0;
  logic            go;
  logic            busy;
  logic            finished;
  logic [RUNW-1:0] ones;
  logic [RUNW-1:0] completed;
  logic            timeout;

  toggle_driver #(.RUNW(RUNW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .runs(runs), .go(go),
    .done_in(done_in), .data_in(data_in), .busy(busy), .finished(finished),
    .ones(ones), .completed(completed), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // Worker behaviour and event log; runs 1ns after each rising edge.
  int   icount = 0, go_cnt = 0, fin_cnt = 0, go_consec = 0, fin_time = 0, go_time = 0;
  logic prev_go = 1'b0, wk_en = 1'b0, armed = 1'b0, wbit = 1'b0;
  int   widx = 0, cnt = 0, hcnt = 0, whold = 0;
  int   wd[8], wh[8], wb[8];

  always @(posedge clock) begin
    #1;
    icount++;
    if (go === 1'b1) begin
      go_cnt++;
      go_time = icount;
      if (prev_go) go_consec++;
    end
    prev_go = (go === 1'b1);
    if (finished === 1'b1) begin
      fin_cnt++;
      fin_time = icount;
    end
    if (!wk_en) begin
      done_in = 1'b0; data_in = 1'b0; armed = 1'b0; widx = 0;
    end else begin
      if (done_in) begin
        hcnt--;
        if (hcnt == 0) begin done_in = 1'b0; data_in = 1'b0; end
      end
      if (go === 1'b1 && widx < 8) begin
        cnt = wd[widx]; wbit = wb[widx][0]; whold = wh[widx]; widx++; armed = 1'b1;
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin armed = 1'b0; done_in = 1'b1; data_in = wbit; hcnt = whold; end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: a run completes iff its done delay fits the watchdog window; offsets relative to start edge.
  task automatic model(input int nr, output int e_go, output int e_ones, output int e_comp,
                       output int e_to, output int e_fin, output int e_lg);
    int g;
    g = 0; e_go = 0; e_ones = 0; e_comp = 0; e_to = 0; e_fin = 0; e_lg = 0;
    for (int k = 0; k < nr; k++) begin
      e_go++;
      e_lg = g;
      if (wd[k] > TO) begin
        e_to  = 1;
        e_fin = g + TO + 1;
        break;
      end
      e_comp++;
      e_ones += wb[k];
      if (k == nr - 1) e_fin = g + wd[k] + 1;
      else             g = g + wd[k] + 1 + ((wh[k] > 1) ? wh[k] : 1);
    end
  endtask

  task automatic do_batch(input string nm, input int nr, input int e_go, input int e_ones,
                          input int e_comp, input int e_to, input int e_fin, input int e_lg,
                          input int xs);
    int t, g0, f0, c0, n;
    wk_en = 1'b0;
    @(negedge clock);
    wk_en = 1'b1;
    g0 = go_cnt; f0 = fin_cnt; c0 = go_consec;
    start = 1'b1; runs = RUNW'(nr); t = icount + 1;
    @(negedge clock);
    start = 1'b0; runs = '0;
    n = 0;
    while (fin_cnt == f0 && n < 400) begin
      start = (n == xs);
      runs  = (n == xs) ? RUNW'(3) : '0;
      @(negedge clock);
      n++;
    end
    start = 1'b0; runs = '0;
    repeat (3) @(negedge clock);
    chk({nm, "_fin_count"}, fin_cnt - f0, 1);
    chk({nm, "_fin_cycle"}, fin_time - t, e_fin);
    chk({nm, "_go_count"}, go_cnt - g0, e_go);
    if (e_go > 0) chk({nm, "_last_go_cycle"}, go_time - t, e_lg);
    chk({nm, "_go_back2back"}, go_consec - c0, 0);
    chk({nm, "_ones"}, int'(ones), e_ones);
    chk({nm, "_completed"}, int'(completed), e_comp);
    chk({nm, "_timeout"}, int'(timeout), e_to);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    int nr;
    int d0, d1, d2;
    int h0, h1, h2;
    int b;
    int e_go, e_ones, e_comp, e_to, e_fin, e_lg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int e_go, e_ones, e_comp, e_to, e_fin, e_lg, nr, g0, f0;
    vecs[0] = '{3, 4, 4, 4,  1, 1, 1, 5, 3, 2, 3, 0, 17, 12};
    vecs[1] = '{0, 1, 1, 1,  1, 1, 1, 0, 0, 0, 0, 0,  0,  0};
    vecs[2] = '{2, 20, 20, 1, 1, 1, 1, 0, 1, 0, 0, 1,  9,  0};
    vecs[3] = '{2, 3, 2, 1,  6, 1, 1, 2, 2, 1, 2, 0, 13, 10};
    vecs[4] = '{1, 8, 1, 1,  1, 1, 1, 1, 1, 1, 1, 0,  9,  0};
    vecs[5] = '{1, 9, 1, 1,  1, 1, 1, 1, 1, 0, 0, 1,  9,  0};
    vecs[6] = '{2, 1, 8, 1,  1, 2, 1, 3, 2, 2, 2, 0, 12,  3};
    vecs[7] = '{3, 2, 2, 9,  1, 1, 1, 7, 3, 2, 2, 1, 17,  8};
    for (int k = 0; k < 8; k++) begin wd[k] = 1; wh[k] = 1; wb[k] = 0; end

    repeat (3) @(negedge clock);
    chk("rst_go", int'(go), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finished", int'(finished), 0);
    chk("rst_ones", int'(ones), 0);
    chk("rst_completed", int'(completed), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      wd[0] = vecs[i].d0; wd[1] = vecs[i].d1; wd[2] = vecs[i].d2;
      wh[0] = vecs[i].h0; wh[1] = vecs[i].h1; wh[2] = vecs[i].h2;
      wb[0] = vecs[i].b & 1; wb[1] = (vecs[i].b >> 1) & 1; wb[2] = (vecs[i].b >> 2) & 1;
      do_batch($sformatf("vec%0d", i), vecs[i].nr, vecs[i].e_go, vecs[i].e_ones,
               vecs[i].e_comp, vecs[i].e_to, vecs[i].e_fin, vecs[i].e_lg, -1);
    end

    // Stray start lands on the same edge as a last-watchdog-cycle completion.
    wd[0] = TO; wh[0] = 1; wb[0] = 0;
    do_batch("start_mid", 1, 1, 0, 1, 0, 9, 0, 8);

    // Reset while waiting; the later done must not disturb the idle block.
    wk_en = 1'b0;
    @(negedge clock);
    wk_en = 1'b1;
    wd[0] = 6; wh[0] = 3; wb[0] = 1;
    g0 = go_cnt; f0 = fin_cnt;
    start = 1'b1; runs = RUNW'(2);
    @(negedge clock);
    start = 1'b0; runs = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_go", int'(go), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_finished", int'(finished), 0);
    repeat (8) @(negedge clock);
    chk("mid_rst_busy_late", int'(busy), 0);
    chk("mid_rst_ones", int'(ones), 0);
    chk("mid_rst_completed", int'(completed), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    chk("mid_rst_no_finish", fin_cnt - f0, 0);
    chk("mid_rst_go_count", go_cnt - g0, 1);

    for (int r = 0; r < 40; r++) begin
      nr = int'($urandom_range(0, 6));
      for (int k = 0; k < 8; k++) begin
        wd[k] = int'($urandom_range(1, TO + 2));
        wh[k] = int'($urandom_range(1, 4));
        wb[k] = int'($urandom_range(0, 1));
      end
      model(nr, e_go, e_ones, e_comp, e_to, e_fin, e_lg);
      do_batch($sformatf("rnd%0d", r), nr, e_go, e_ones, e_comp, e_to, e_fin, e_lg, -1);
    end

    chk("go_back2back_total", go_consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit actual=%0d required=0", icount);
    $fatal(1, "time limit");
  end

endmodule
